// File: rtl/score_bcd_seq_pkg.sv
// Shared types and constants for the score display BCD path.
// Holds digit width, the FSM state type and a power-of-ten helper.
package score_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } bcd_state_t;

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] r;
      r = 32'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 32'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/score_bcd_seq_digit.sv
// One double-dabble correction cell: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_dabble_digit
   import score_pkg::*;
(
   input  logic [BCD_W-1:0] i_digit,
   output logic [BCD_W-1:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/score_bcd_seq.sv
// Iterative binary-to-BCD converter for the score display, one input bit
// per cycle, with saturation on overflow and leading-zero blank flags.
module score_bcd_seq
   import score_pkg::*;
#(
   parameter int IN_W   = 20,
   parameter int DIGITS = 7
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [IN_W-1:0]         value,
   output logic                    busy,
   output logic                    done,
   output logic [BCD_W*DIGITS-1:0] digits,
   output logic [DIGITS-1:0]       blank,
   output logic                    overflow
);

   localparam int ACC_W = BCD_W * DIGITS;
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int CMP_W = (IN_W > 32) ? IN_W : 32;

   localparam logic [CMP_W-1:0] LIMIT    = CMP_W'(pow10(DIGITS));
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_W - 1);
   localparam logic [ACC_W-1:0] NINES    = {DIGITS{4'h9}};

   bcd_state_t         r_state;
   bcd_state_t         w_state_nxt;
   logic [IN_W-1:0]    r_sh;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf_q;
   logic [ACC_W-1:0]   r_digits;
   logic               r_ovf;
   logic [ACC_W-1:0]   w_adj;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic               w_ovf;
   logic               w_last;
   logic [DIGITS-1:0]  w_blank;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_dabble_digit u_dig (
         .i_digit (r_acc[g*BCD_W +: BCD_W]),
         .o_digit (w_adj[g*BCD_W +: BCD_W])
      );
   end

   // Top accumulator bit is dropped; it only matters on overflow,
   // where the saturated result replaces it anyway.
   assign w_acc_nxt = {w_adj[ACC_W-2:0], r_sh[IN_W-1]};
   assign w_ovf     = (CMP_W'(value) >= LIMIT);
   assign w_last    = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = SHIFT;
         SHIFT:   if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != IDLE);
      done = (r_state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_sh     <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_ovf_q  <= 1'b0;
         r_digits <= '0;
         r_ovf    <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_sh    <= value;
                  r_acc   <= '0;
                  r_cnt   <= CNT_INIT;
                  r_ovf_q <= w_ovf;
               end
            end
            SHIFT: begin
               r_acc <= w_acc_nxt;
               r_sh  <= r_sh << 1;
               r_cnt <= r_cnt - CNT_W'(1);
               // Result lands with the DONE state so it is valid with done.
               if (w_last) begin
                  r_digits <= r_ovf_q ? NINES : w_acc_nxt;
                  r_ovf    <= r_ovf_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      logic v_run;
      w_blank = '0;
      v_run   = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         v_run      = v_run & (r_digits[i*BCD_W +: BCD_W] == 4'd0);
         w_blank[i] = v_run;
      end
   end

   assign digits   = r_digits;
   assign blank    = w_blank;
   assign overflow = r_ovf;

endmodule
